// File: rtl/reg16_byte_reader.sv
// Purpose: reads a run of 16-bit registers via the half-select port and streams each one as two bytes, low then high.
// Latency: first byte valid 2 cycles after start; 2 cycles/byte with out_ready high; done 4N+1 cycles after start.
// Backpressure: a byte is held stable on out_data with out_valid high until out_ready accepts it.
module reg16_byte_reader #(
  parameter int NREG = 8,
  parameter int AW   = 3
) (
  input  logic          C,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  output logic [AW-1:0] reg_addr,
  output logic [1:0]    reg_half,
  input  logic [15:0]   reg_q,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done,
  output logic          protocol_err
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_LO = 3'd1,
    SEND_LO = 3'd2,
    LOAD_HI = 3'd3,
    SEND_HI = 3'd4,
    DONE_S  = 3'd5
  } state_t;

  localparam logic [1:0]  HALF_FULL = 2'b00;
  localparam logic [1:0]  HALF_LO   = 2'b01;
  localparam logic [1:0]  HALF_HI   = 2'b10;
  localparam logic [AW:0] ONE       = (AW+1)'(1);
  localparam logic [AW:0] NREG_W    = (AW+1)'(NREG);

  state_t        state_q, state_d;
  logic [AW-1:0] reg_addr_q, reg_addr_d;
  logic [1:0]    reg_half_q, reg_half_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          protocol_err_q, protocol_err_d;
  logic [AW:0]   remaining_q, remaining_d;

  logic [AW:0]   addr_inc;
  logic          hi_nonzero;

  // Address step wraps at NREG; the bank must return zero in the top byte for half reads.
  assign addr_inc   = {1'b0, reg_addr_q} + ONE;
  assign hi_nonzero = |reg_q[15:8];

  // Next-state and next-output computation; all outputs are registered from these.
  always_comb begin
    state_d        = state_q;
    reg_addr_d     = reg_addr_q;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    protocol_err_d = protocol_err_q;
    remaining_d    = remaining_q;
    reg_half_d     = HALF_FULL;
    busy_d         = 1'b0;
    done_d         = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          protocol_err_d = 1'b0;
          if (count != '0) begin
            reg_addr_d  = base_addr;
            remaining_d = count;
            state_d     = LOAD_LO;
          end else begin
            state_d = DONE_S;
          end
        end
      end
      LOAD_LO: begin
        out_data_d  = reg_q[7:0];
        out_valid_d = 1'b1;
        if (hi_nonzero) protocol_err_d = 1'b1;
        state_d = SEND_LO;
      end
      SEND_LO: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = LOAD_HI;
        end
      end
      LOAD_HI: begin
        out_data_d  = reg_q[7:0];
        out_valid_d = 1'b1;
        if (hi_nonzero) protocol_err_d = 1'b1;
        state_d = SEND_HI;
      end
      SEND_HI: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          remaining_d = remaining_q - ONE;
          if (remaining_q == ONE) begin
            state_d = DONE_S;
          end else begin
            reg_addr_d = (addr_inc == NREG_W) ? '0 : addr_inc[AW-1:0];
            state_d    = LOAD_LO;
          end
        end
      end
      DONE_S: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Half select, busy and done follow the state being entered so they line up with it.
    case (state_d)
      LOAD_LO, SEND_LO: reg_half_d = HALF_LO;
      LOAD_HI, SEND_HI: reg_half_d = HALF_HI;
      default:          reg_half_d = HALF_FULL;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE_S);
  end

  // State and output registers; reset clears everything immediately, abandoning any burst.
  always_ff @(posedge C or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      reg_addr_q     <= '0;
      reg_half_q     <= HALF_FULL;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      protocol_err_q <= 1'b0;
      remaining_q    <= '0;
    end else begin
      state_q        <= state_d;
      reg_addr_q     <= reg_addr_d;
      reg_half_q     <= reg_half_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      protocol_err_q <= protocol_err_d;
      remaining_q    <= remaining_d;
    end
  end

  assign reg_addr     = reg_addr_q;
  assign reg_half     = reg_half_q;
  assign out_data     = out_data_q;
  assign out_valid    = out_valid_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign protocol_err = protocol_err_q;

endmodule

// File: tb/tb_reg16_byte_reader.sv
// Bench for reg16_byte_reader: a register bank model feeds the DUT, a handshake monitor
// collects the byte stream, and each burst is compared against a list built from the bank
// contents with plain arithmetic.
`timescale 1ns/1ps
module tb_reg16_byte_reader;
  localparam int NREG = 8;
  localparam int AW   = 3;

  logic          C = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   count = '0;
  logic [AW-1:0] reg_addr;
  logic [1:0]    reg_half;
  logic [15:0]   reg_q;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          protocol_err;

  logic [15:0]   bank [NREG];
  bit            inj = 1'b0;

  int total = 0;
  int bad   = 0;

  // Burst results and expectations
  logic [7:0]    got_b[$];
  logic [7:0]    exp_b[$];
  logic [AW-1:0] got_a[$];
  logic [AW-1:0] exp_a[$];
  int first_v, done_t, done_n, viol;
  bit busy_done, busy_after, err_done, err_t2, tmo;

  reg16_byte_reader #(.NREG(NREG), .AW(AW)) dut (
    .C(C), .rst(rst), .start(start), .base_addr(base_addr), .count(count),
    .reg_addr(reg_addr), .reg_half(reg_half), .reg_q(reg_q),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .done(done), .protocol_err(protocol_err)
  );

  always #5 C = ~C;

  // Bank: half reads return the selected byte zero-extended; inj corrupts low-half reads to 0x0100.
  always_comb begin
    case (reg_half)
      2'b01:   reg_q = inj ? 16'h0100 : {8'h00, bank[reg_addr][7:0]};
      2'b10:   reg_q = {8'h00, bank[reg_addr][15:8]};
      default: reg_q = bank[reg_addr];
    endcase
  end

  // Expected stream: for each of n consecutive registers (mod NREG), low byte then high byte.
  task automatic model_burst(input int b, input int n);
    exp_b.delete();
    exp_a.delete();
    for (int i = 0; i < n; i++) begin
      int a;
      a = (b + i) % NREG;
      exp_b.push_back(inj ? 8'h00 : bank[a][7:0]);
      exp_b.push_back(bank[a][15:8]);
      exp_a.push_back(AW'(a));
      exp_a.push_back(AW'(a));
    end
  endtask

  function automatic bit bytes_match();
    if (got_b.size() != exp_b.size()) return 1'b0;
    foreach (got_b[i]) if (got_b[i] !== exp_b[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit addrs_match();
    if (got_a.size() != exp_a.size()) return 1'b0;
    foreach (got_a[i]) if (got_a[i] !== exp_a[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Start a burst and monitor it until shortly after done (or a cycle budget expires).
  // Called at posedge+1; t counts edges since the start edge.
  task automatic run_burst(input int b, input int n, input int pct, input int stall, input bit poke);
    bit pv, pr;
    logic [7:0] pd;
    int t, stall_left;
    got_b.delete();
    got_a.delete();
    first_v = -1; done_t = -1; done_n = 0; viol = 0;
    busy_done = 1'b0; busy_after = 1'b1; err_done = 1'b0; err_t2 = 1'b0; tmo = 1'b0;
    pv = 1'b0; pr = 1'b0; pd = '0; t = 0; stall_left = stall;
    base_addr = AW'(b);
    count     = (AW+1)'(n);
    start     = 1'b1;
    @(posedge C); #1;
    start = 1'b0;
    forever begin
      t++;
      if (pv && !pr && (!out_valid || out_data !== pd)) viol++;
      if (out_valid && first_v < 0) first_v = t;
      if (t == 2) err_t2 = protocol_err;
      if (done) begin
        done_n++;
        if (done_t < 0) begin
          done_t    = t;
          busy_done = busy;
          err_done  = protocol_err;
        end
      end
      if (done_t >= 0 && t == done_t + 1) busy_after = busy;
      if (done_t >= 0 && t == done_t + 3) break;
      if (t > 400) begin
        tmo = 1'b1;
        break;
      end
      if (out_valid && stall_left > 0) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = ($urandom_range(99) < pct);
      end
      if (out_valid && out_ready) begin
        got_b.push_back(out_data);
        got_a.push_back(reg_addr);
      end
      pv = out_valid; pr = out_ready; pd = out_data;
      if (poke && t == 3) begin
        start     = 1'b1;
        base_addr = ~AW'(b);
        count     = (AW+1)'(5);
      end else begin
        start = 1'b0;
      end
      @(posedge C); #1;
    end
    out_ready = 1'b0;
    start     = 1'b0;
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
    total++; if (protocol_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", protocol_err); end
    total++; if (reg_addr !== 3'd0) begin bad++; $display("FAIL reset_addr: got %0d want 0", reg_addr); end
    total++; if (reg_half !== 2'b00) begin bad++; $display("FAIL reset_half: got %b want 00", reg_half); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", out_data); end
    @(posedge C); @(posedge C); #1;
    rst = 1'b0;
    @(posedge C); #1;
    total++; if (busy !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL idle_after_reset: busy=%b valid=%b want 0 0", busy, out_valid); end
  endtask

  task automatic test_basic();
    inj = 1'b0;
    bank[0] = 16'h1234; bank[1] = 16'hABCD;
    model_burst(0, 2);
    run_burst(0, 2, 100, 0, 1'b0);
    total++; if (tmo) begin bad++; $display("FAIL basic_timeout: burst did not finish"); end
    total++; if (!bytes_match()) begin bad++; $display("FAIL basic_bytes: got %p want %p", got_b, exp_b); end
    total++; if (first_v != 2) begin bad++; $display("FAIL basic_first_valid: got %0d want 2", first_v); end
    total++; if (done_t != 9) begin bad++; $display("FAIL basic_done_time: got %0d want 9", done_t); end
    total++; if (done_n != 1) begin bad++; $display("FAIL basic_done_count: got %0d want 1", done_n); end
    total++; if (busy_done !== 1'b1) begin bad++; $display("FAIL basic_busy_in_done: got %b want 1", busy_done); end
    total++; if (busy_after !== 1'b0) begin bad++; $display("FAIL basic_busy_after: got %b want 0", busy_after); end
  endtask

  task automatic test_wrap();
    bank[7] = 16'h00FF; bank[0] = 16'h5500;
    model_burst(7, 2);
    run_burst(7, 2, 100, 0, 1'b0);
    total++; if (!bytes_match()) begin bad++; $display("FAIL wrap_bytes: got %p want %p", got_b, exp_b); end
    total++; if (!addrs_match()) begin bad++; $display("FAIL wrap_addrs: got %p want %p", got_a, exp_a); end
    total++; if (done_t != 9) begin bad++; $display("FAIL wrap_done_time: got %0d want 9", done_t); end
  endtask

  task automatic test_backpressure();
    bank[0] = 16'hBEEF;
    model_burst(0, 1);
    run_burst(0, 1, 100, 5, 1'b0);
    total++; if (viol != 0) begin bad++; $display("FAIL bp_stable: got %0d stability violations want 0", viol); end
    total++; if (!bytes_match()) begin bad++; $display("FAIL bp_bytes: got %p want %p", got_b, exp_b); end
    total++; if (done_t != 10) begin bad++; $display("FAIL bp_done_time: got %0d want 10", done_t); end
  endtask

  task automatic test_protocol_err();
    inj = 1'b1;
    bank[2] = 16'h1357; bank[3] = 16'h2468;
    model_burst(2, 2);
    run_burst(2, 2, 100, 0, 1'b0);
    inj = 1'b0;
    total++; if (err_t2 !== 1'b1) begin bad++; $display("FAIL err_after_load: got %b want 1", err_t2); end
    total++; if (err_done !== 1'b1) begin bad++; $display("FAIL err_at_done: got %b want 1", err_done); end
    total++; if (protocol_err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", protocol_err); end
    total++; if (!bytes_match()) begin bad++; $display("FAIL err_bytes: got %p want %p", got_b, exp_b); end
  endtask

  task automatic test_zero_count();
    model_burst(0, 0);
    run_burst(0, 0, 100, 0, 1'b0);
    total++; if (got_b.size() != 0 || first_v != -1) begin bad++; $display("FAIL zero_no_bytes: got %0d bytes first_valid=%0d want 0 -1", got_b.size(), first_v); end
    total++; if (done_t != 1) begin bad++; $display("FAIL zero_done_time: got %0d want 1", done_t); end
    total++; if (done_n != 1) begin bad++; $display("FAIL zero_done_count: got %0d want 1", done_n); end
    total++; if (err_done !== 1'b0) begin bad++; $display("FAIL zero_err_cleared: got %b want 0", err_done); end
  endtask

  task automatic test_busy_start();
    for (int i = 0; i < NREG; i++) bank[i] = 16'($urandom);
    model_burst(4, 3);
    run_burst(4, 3, 100, 0, 1'b1);
    total++; if (!bytes_match()) begin bad++; $display("FAIL busy_start_bytes: got %p want %p", got_b, exp_b); end
    total++; if (done_t != 13) begin bad++; $display("FAIL busy_start_done_time: got %0d want 13", done_t); end
    total++; if (done_n != 1) begin bad++; $display("FAIL busy_start_done_count: got %0d want 1", done_n); end
  endtask

  task automatic test_random();
    for (int it = 0; it < 24; it++) begin
      int b, n, pct;
      for (int i = 0; i < NREG; i++) bank[i] = 16'($urandom);
      b   = int'($urandom_range(NREG - 1));
      n   = int'($urandom_range(2 * NREG - 1));
      pct = (it % 4 == 0) ? 100 : int'($urandom_range(100, 30));
      model_burst(b, n);
      run_burst(b, n, pct, 0, 1'b0);
      total++; if (tmo) begin bad++; $display("FAIL rnd_timeout: it=%0d base=%0d n=%0d", it, b, n); end
      total++; if (!bytes_match()) begin bad++; $display("FAIL rnd_bytes: it=%0d got %p want %p", it, got_b, exp_b); end
      total++; if (!addrs_match()) begin bad++; $display("FAIL rnd_addrs: it=%0d got %p want %p", it, got_a, exp_a); end
      total++; if (done_n != 1 || busy_after !== 1'b0) begin bad++; $display("FAIL rnd_done: it=%0d done_n=%0d busy_after=%b want 1 0", it, done_n, busy_after); end
      total++; if (viol != 0) begin bad++; $display("FAIL rnd_stable: it=%0d got %0d violations want 0", it, viol); end
      if (pct == 100) begin
        total++; if (done_t != 4 * n + 1) begin bad++; $display("FAIL rnd_done_time: it=%0d got %0d want %0d", it, done_t, 4 * n + 1); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    int dn;
    found = 1'b0;
    dn = 0;
    for (int i = 0; i < NREG; i++) bank[i] = 16'($urandom);
    base_addr = 3'd3; count = 4'd3; start = 1'b1;
    @(posedge C); #1;
    start = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (out_valid && reg_half == 2'b10) begin
        found = 1'b1;
        break;
      end
      out_ready = 1'b1;
      @(posedge C); #1;
    end
    out_ready = 1'b0;
    total++; if (!found) begin bad++; $display("FAIL rmid_reach_send_hi: not reached within budget"); end
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || busy !== 1'b0 || reg_addr !== 3'd0) begin bad++; $display("FAIL rmid_async: valid=%b busy=%b addr=%0d want 0 0 0", out_valid, busy, reg_addr); end
    @(posedge C); #1;
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (done) dn++;
      @(posedge C); #1;
    end
    total++; if (dn != 0 || busy !== 1'b0) begin bad++; $display("FAIL rmid_no_done: done pulses=%0d busy=%b want 0 0", dn, busy); end
    model_burst(5, 2);
    run_burst(5, 2, 100, 0, 1'b0);
    total++; if (!bytes_match() || done_t != 9) begin bad++; $display("FAIL rmid_recover: got %p done_t=%0d want %p 9", got_b, done_t, exp_b); end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) bank[i] = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_protocol_err();
    test_zero_count();
    test_busy_start();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
